mdl_dacrx: RTL
==============

MDL_DACRX -- requirements
Module: mdl_dacrx

Interface
REQ-001 SHALL have port: i_EMUCLK  input  1  emulator master clock; all state changes on its rising edge.
REQ-002 SHALL have port: i_IC_n  input  1  reset, asynchronous, active-low; one clock, reset asynchronous active-low.
REQ-003 SHALL have port: i_phi1_NCEN_n  input  1  active-low bit-slot clock enable (phi1 negative-edge enable); all protocol sampling only on cycles where it is low.
REQ-004 SHALL have port: i_SO  input  1  serial DAC data, LSB first, one bit per enable.
REQ-005 SHALL have port: i_SH1  input  1  channel-1 (left) sample-hold strobe; its falling edge closes a left frame.
REQ-006 SHALL have port: i_SH2  input  1  channel-2 (right) sample-hold strobe; its falling edge closes a right frame.
REQ-007 SHALL have port: o_L  output  16  signed linear left sample.
REQ-008 SHALL have port: o_R  output  16  signed linear right sample.
REQ-009 SHALL have port: o_L_VALID / o_R_VALID  output  1 each  one-EMUCLK pulse when o_L / o_R update.
REQ-010 SHALL have port: o_FRAME_ERR  output  1  sticky; set on a malformed frame; cleared only by reset.
REQ-011 SHALL have port: o_SYNCED  output  1  high once the first valid strobe edge has been seen.

Function
REQ-012 On each enable, SHALL shift i_SO into a 16-bit shift register (new bit enters at MSB, LSB-first framing) and register i_SH1/i_SH2 for edge detection.
REQ-013 Falling edge SHALL be defined as registered SHx=1 and current SHx=0 at the same enable.
REQ-014 On a falling-edge enable, the completed frame SHALL be the shift register content before this enable's shift; this enable's i_SO bit SHALL become bit 0 of the next frame; the bit counter SHALL load 1.
REQ-015 Bit counter: 5 bits, +1 per enable, saturating at 31.
REQ-016 Frame word W fields: W[2:0] ignored, W[12:3] mantissa (10-bit two's complement), W[15:13] exponent.
REQ-017 Decode: exponent 0 -> output 0; exponent e in 1..7 -> sign-extended mantissa shifted left by (e-1), 16-bit signed, no saturation needed (max magnitude fits).
REQ-018 FSM states UNSYNC, SYNC; UNSYNC->SYNC on first falling edge of either strobe, with that edge's frame discarded (no VALID); no transition back except by reset.
REQ-019 In SYNC, frame closure with counter == 16 SHALL capture; counter != 16 SHALL set o_FRAME_ERR and discard the frame.
REQ-020 Simultaneous SH1 and SH2 falling edges SHALL set o_FRAME_ERR, discard, and restart the counter at 1.
REQ-021 Captured word SHALL be decoded and registered into o_L or o_R exactly 1 EMUCLK after the capture enable, with the matching VALID high for that single EMUCLK cycle; the other channel holds.
REQ-022 Strobe levels held high across many enables SHALL have no effect other than shifting.

Reset
REQ-023 Asynchronous assertion of i_IC_n low SHALL clear: shift register 0, counter 0, registered strobes 0, FSM UNSYNC, o_L 0, o_R 0, VALIDs 0, o_FRAME_ERR 0, o_SYNCED 0.
REQ-024 Reset mid-frame SHALL drop the partial frame; after release, resynchronisation per REQ-018.

Structure
REQ-025 Shared package SHALL hold FRAME_BITS=16, mantissa/exponent bit positions and the FSM state type.
REQ-026 Float-to-linear decode SHALL be the combinational sub-module mdl_dacrx_decode (10-bit mantissa + 3-bit exponent -> 16-bit signed).

Verification
REQ-027 Reset then SH1 edge, then 16 bits W=0xEFF8 and an SH1 falling edge -> o_L=0x7FC0, o_L_VALID one pulse, o_R=0.
REQ-028 SH2 frame W=0xF000 (mantissa 0x200, exp 7) -> o_R=0x8000, o_R_VALID pulse, o_L unchanged.
REQ-029 Frames with exp 1 mantissa 0x005 (W=0x2028) -> 0x0005; exp 0 any mantissa (W=0x1FF8) -> 0x0000 with VALID still pulsing.
REQ-030 In SYNC, SH1 edge after only 15 bits -> no VALID, o_FRAME_ERR=1 and stays 1 for subsequent good frames, which still decode correctly.
REQ-031 SH1 and SH2 fall at the same enable -> o_FRAME_ERR=1, no VALID; first edge after reset -> o_SYNCED=1, no VALID.
REQ-032 i_IC_n low mid-frame -> all outputs 0 immediately (asynchronous), next edge only resynchronises.

Source files
------------

// File: rtl/mdl_dacrx_pkg.sv
// Shared constants and types for the serial DAC receiver: frame geometry,
// float-field positions inside a frame word, and the sync FSM state type.
package mdl_dacrx_pkg;
   localparam int FRAME_BITS = 16;
   localparam int CNT_W      = 5;
   localparam int MANT_LSB   = 3;
   localparam int MANT_MSB   = 12;
   localparam int EXP_LSB    = 13;
   localparam int EXP_MSB    = 15;
   localparam int MANT_W     = MANT_MSB - MANT_LSB + 1;
   localparam int EXP_W      = EXP_MSB - EXP_LSB + 1;

   localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {
      ST_UNSYNC = 1'b0,
      ST_SYNC   = 1'b1
   } state_t;
endpackage

// File: rtl/mdl_dacrx_decode.sv
// Float-to-linear conversion: 10-bit two's complement mantissa scaled by
// 2^(exp-1); exponent 0 means silence.
module mdl_dacrx_decode
   import mdl_dacrx_pkg::*;
(
   input  logic [MANT_W-1:0]     i_mant,
   input  logic [EXP_W-1:0]      i_exp,
   output logic [FRAME_BITS-1:0] o_lin
);

   logic [FRAME_BITS-1:0] w_sext;

   assign w_sext = {{(FRAME_BITS-MANT_W){i_mant[MANT_W-1]}}, i_mant};

   // Largest shift is 6, so a 10-bit mantissa always fits in 16 bits.
   always_comb begin
      o_lin = '0;
      if (i_exp != '0) begin
         o_lin = w_sext << (i_exp - 3'd1);
      end
   end

endmodule

// File: rtl/mdl_dacrx.sv
// Serial DAC receiver: deserialises LSB-first frames delimited by the
// SH1/SH2 falling edges and converts each floating-point word to linear PCM.
module mdl_dacrx
   import mdl_dacrx_pkg::*;
(
   input  logic                  i_EMUCLK,
   input  logic                  i_IC_n,
   input  logic                  i_phi1_NCEN_n,
   input  logic                  i_SO,
   input  logic                  i_SH1,
   input  logic                  i_SH2,
   output logic [FRAME_BITS-1:0] o_L,
   output logic [FRAME_BITS-1:0] o_R,
   output logic                  o_L_VALID,
   output logic                  o_R_VALID,
   output logic                  o_FRAME_ERR,
   output logic                  o_SYNCED
);

   state_t                r_state;
   state_t                w_state_next;
   logic [FRAME_BITS-1:0] r_shift;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_sh1;
   logic                  r_sh2;
   logic                  r_cap;
   logic                  r_cap_ch;
   logic [FRAME_BITS-1:0] r_cap_word;
   logic [FRAME_BITS-1:0] r_L;
   logic [FRAME_BITS-1:0] r_R;
   logic                  r_l_valid;
   logic                  r_r_valid;
   logic                  r_err;
   logic                  w_en;
   logic                  w_fall1;
   logic                  w_fall2;
   logic                  w_capture;
   logic                  w_err_set;
   logic [FRAME_BITS-1:0] w_lin;

   assign w_en    = ~i_phi1_NCEN_n;
   assign w_fall1 = w_en & r_sh1 & ~i_SH1;
   assign w_fall2 = w_en & r_sh2 & ~i_SH2;

   always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
         r_state <= ST_UNSYNC;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_err_set    = 1'b0;
      case (r_state)
         ST_UNSYNC: begin
            // The first edge only establishes frame alignment.
            if (w_fall1 | w_fall2) begin
               w_state_next = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (w_fall1 & w_fall2) begin
               w_err_set = 1'b1;
            end else if (w_fall1 | w_fall2) begin
               if (r_cnt == CNT_FRAME) begin
                  w_capture = 1'b1;
               end else begin
                  w_err_set = 1'b1;
               end
            end
         end
         default: w_state_next = ST_UNSYNC;
      endcase
   end

   always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
         r_shift    <= '0;
         r_cnt      <= '0;
         r_sh1      <= 1'b0;
         r_sh2      <= 1'b0;
         r_cap      <= 1'b0;
         r_cap_ch   <= 1'b0;
         r_cap_word <= '0;
         r_L        <= '0;
         r_R        <= '0;
         r_l_valid  <= 1'b0;
         r_r_valid  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_cap <= w_capture;
         // The closed frame is the register content before this enable's shift.
         if (w_capture) begin
            r_cap_word <= r_shift;
            r_cap_ch   <= w_fall2;
         end
         if (w_en) begin
            r_shift <= {i_SO, r_shift[FRAME_BITS-1:1]};
            r_sh1   <= i_SH1;
            r_sh2   <= i_SH2;
            if (w_fall1 | w_fall2) begin
               r_cnt <= CNT_W'(1);
            end else if (r_cnt != CNT_MAX) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
         r_l_valid <= r_cap & ~r_cap_ch;
         r_r_valid <= r_cap & r_cap_ch;
         if (r_cap & ~r_cap_ch) begin
            r_L <= w_lin;
         end
         if (r_cap & r_cap_ch) begin
            r_R <= w_lin;
         end
      end
   end

   mdl_dacrx_decode u_decode (
      .i_mant (r_cap_word[MANT_MSB:MANT_LSB]),
      .i_exp  (r_cap_word[EXP_MSB:EXP_LSB]),
      .o_lin  (w_lin)
   );

   assign o_L         = r_L;
   assign o_R         = r_R;
   assign o_L_VALID   = r_l_valid;
   assign o_R_VALID   = r_r_valid;
   assign o_FRAME_ERR = r_err;
   assign o_SYNCED    = (r_state == ST_SYNC);

endmodule
